// File: rtl/rx_token_check_if.sv
// Receive-side token checker bus: deserializer inputs plus decoded results.
// Master drives the received byte stream; slave (the checker) drives the results.
interface rx_token_check_if #(
    parameter int CNT_W = 8
);
    logic             rx_sop;
    logic             rx_byte_valid;
    logic [7:0]       rx_byte;
    logic             rx_eop;
    logic             rx_handshake_on;

    logic             rx_pid_en;
    logic [3:0]       rx_pid;
    logic [6:0]       rx_addr;
    logic [3:0]       rx_endp;
    logic             rx_err_en;
    logic [1:0]       rx_err_code;
    logic [CNT_W-1:0] crc_err_cnt;
    logic [CNT_W-1:0] pid_err_cnt;

    modport master (
        output rx_sop, rx_byte_valid, rx_byte, rx_eop, rx_handshake_on,
        input  rx_pid_en, rx_pid, rx_addr, rx_endp, rx_err_en, rx_err_code,
        input  crc_err_cnt, pid_err_cnt
    );

    modport slave (
        input  rx_sop, rx_byte_valid, rx_byte, rx_eop, rx_handshake_on,
        output rx_pid_en, rx_pid, rx_addr, rx_endp, rx_err_en, rx_err_code,
        output crc_err_cnt, pid_err_cnt
    );
endinterface

// File: rtl/rx_token_check.sv
// USB TOKEN/HANDSHAKE checker: PID check, CRC5, length; emits rx_pid_en with addr/endp.
// Latency: one cycle from the triggering byte/eop/sop to the registered pulse.
// No backpressure: the byte stream is consumed at line rate, one byte per strobe.
module rx_token_check #(
    parameter int CNT_W = 8
) (
    input  logic           clk,
    input  logic           rst,
    rx_token_check_if.slave bus
);

    typedef enum logic [2:0] {
        IDLE,
        PID,
        TOK1,
        TOK2,
        WAIT_EOP,
        IGNORE
    } state_t;

    localparam logic [1:0]       ERR_PID  = 2'b01;
    localparam logic [1:0]       ERR_CRC  = 2'b10;
    localparam logic [1:0]       ERR_LEN  = 2'b11;
    localparam logic [4:0]       CRC_INIT = 5'b11111;
    localparam logic [4:0]       CRC_GOOD = 5'b01100;
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
    localparam logic [CNT_W-1:0] CNT_MAX  = '1;

    // Eight serial CRC5 steps, LSB of the byte first (wire order).
    function automatic logic [4:0] crc5_byte(input logic [4:0] crc_in, input logic [7:0] d);
        logic [4:0] c;
        logic       fb;
        c = crc_in;
        for (int i = 0; i < 8; i++) begin
            fb = c[4] ^ d[i];
            c  = {c[3:0], 1'b0} ^ (fb ? 5'b00101 : 5'b00000);
        end
        return c;
    endfunction

    state_t           state_q;
    state_t           state_nxt;
    state_t           post_st;
    logic [4:0]       crc_q;
    logic [4:0]       crc_nxt;
    logic [3:0]       pend_pid_q;
    logic [3:0]       pend_pid_nxt;
    logic [6:0]       pend_addr_q;
    logic [6:0]       pend_addr_nxt;
    logic [3:0]       pend_endp_q;
    logic [3:0]       pend_endp_nxt;

    logic             pid_pulse;
    logic             upd_token;
    logic             err_pulse;
    logic [1:0]       err_code_nxt;
    logic             crc_inc;
    logic             pid_inc;

    logic             pid_en_q;
    logic [3:0]       pid_q;
    logic [6:0]       addr_q;
    logic [3:0]       endp_q;
    logic             err_en_q;
    logic [1:0]       err_code_q;
    logic [CNT_W-1:0] crc_cnt_q;
    logic [CNT_W-1:0] pid_cnt_q;

    always_comb begin
        state_nxt     = state_q;
        post_st       = state_q;
        crc_nxt       = crc_q;
        pend_pid_nxt  = pend_pid_q;
        pend_addr_nxt = pend_addr_q;
        pend_endp_nxt = pend_endp_q;
        pid_pulse     = 1'b0;
        upd_token     = 1'b0;
        err_pulse     = 1'b0;
        err_code_nxt  = ERR_LEN;
        crc_inc       = 1'b0;
        pid_inc       = 1'b0;

        if (bus.rx_sop) begin
            // A new start while a packet is still open aborts it; any same-cycle byte is dropped.
            if (state_q != IDLE && state_q != IGNORE) begin
                err_pulse    = 1'b1;
                err_code_nxt = ERR_LEN;
            end
            state_nxt = PID;
        end else begin
            if (bus.rx_byte_valid) begin
                case (state_q)
                    PID: begin
                        if (bus.rx_byte[7:4] != ~bus.rx_byte[3:0]) begin
                            err_pulse    = 1'b1;
                            err_code_nxt = ERR_PID;
                            pid_inc      = 1'b1;
                            post_st      = IGNORE;
                        end else begin
                            pend_pid_nxt = bus.rx_byte[3:0];
                            crc_nxt      = CRC_INIT;
                            case (bus.rx_byte[1:0])
                                2'b01:   post_st = TOK1;
                                2'b10:   post_st = WAIT_EOP;
                                default: post_st = IGNORE;
                            endcase
                        end
                    end
                    TOK1: begin
                        pend_addr_nxt = bus.rx_byte[6:0];
                        pend_endp_nxt = {pend_endp_q[3:1], bus.rx_byte[7]};
                        crc_nxt       = crc5_byte(crc_q, bus.rx_byte);
                        post_st       = TOK2;
                    end
                    TOK2: begin
                        pend_endp_nxt = {bus.rx_byte[2:0], pend_endp_q[0]};
                        crc_nxt       = crc5_byte(crc_q, bus.rx_byte);
                        post_st       = WAIT_EOP;
                    end
                    WAIT_EOP: begin
                        err_pulse    = 1'b1;
                        err_code_nxt = ERR_LEN;
                        post_st      = IGNORE;
                    end
                    default: ;
                endcase
            end

            state_nxt = post_st;

            // End-of-packet is judged against the state after this cycle's byte.
            if (bus.rx_eop) begin
                case (post_st)
                    PID, TOK1, TOK2: begin
                        err_pulse    = 1'b1;
                        err_code_nxt = ERR_LEN;
                        state_nxt    = IDLE;
                    end
                    WAIT_EOP: begin
                        state_nxt = IDLE;
                        if (pend_pid_nxt[1:0] == 2'b01) begin
                            if (crc_nxt == CRC_GOOD) begin
                                pid_pulse = 1'b1;
                                upd_token = 1'b1;
                            end else begin
                                err_pulse    = 1'b1;
                                err_code_nxt = ERR_CRC;
                                crc_inc      = 1'b1;
                            end
                        end else if (bus.rx_handshake_on) begin
                            pid_pulse = 1'b1;
                        end
                    end
                    IGNORE:  state_nxt = IDLE;
                    default: ;
                endcase
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= IDLE;
            crc_q       <= CRC_INIT;
            pend_pid_q  <= '0;
            pend_addr_q <= '0;
            pend_endp_q <= '0;
            pid_en_q    <= 1'b0;
            pid_q       <= '0;
            addr_q      <= '0;
            endp_q      <= '0;
            err_en_q    <= 1'b0;
            err_code_q  <= '0;
            crc_cnt_q   <= '0;
            pid_cnt_q   <= '0;
        end else begin
            state_q     <= state_nxt;
            crc_q       <= crc_nxt;
            pend_pid_q  <= pend_pid_nxt;
            pend_addr_q <= pend_addr_nxt;
            pend_endp_q <= pend_endp_nxt;
            pid_en_q    <= pid_pulse;
            err_en_q    <= err_pulse;
            if (pid_pulse) begin
                pid_q <= pend_pid_nxt;
            end
            if (upd_token) begin
                addr_q <= pend_addr_nxt;
                endp_q <= pend_endp_nxt;
            end
            if (err_pulse) begin
                err_code_q <= err_code_nxt;
            end
            if (crc_inc && crc_cnt_q != CNT_MAX) begin
                crc_cnt_q <= crc_cnt_q + CNT_ONE;
            end
            if (pid_inc && pid_cnt_q != CNT_MAX) begin
                pid_cnt_q <= pid_cnt_q + CNT_ONE;
            end
        end
    end

    assign bus.rx_pid_en   = pid_en_q;
    assign bus.rx_pid      = pid_q;
    assign bus.rx_addr     = addr_q;
    assign bus.rx_endp     = endp_q;
    assign bus.rx_err_en   = err_en_q;
    assign bus.rx_err_code = err_code_q;
    assign bus.crc_err_cnt = crc_cnt_q;
    assign bus.pid_err_cnt = pid_cnt_q;

endmodule

// File: tb/tb_rx_token_check.sv
// Bench for rx_token_check: directed packets, expected pulses queued by the stimulus
// and popped by an independent monitor whenever the DUT raises rx_pid_en or rx_err_en.
module tb_rx_token_check;

    logic clk;
    logic rst;
    int   cyc = 0;
    int   n_chk = 0;
    int   n_fail = 0;

    typedef struct {
        bit         is_err;
        logic [3:0] pid;
        logic [6:0] addr;
        logic [3:0] endp;
        logic [1:0] code;
        int         cyc;
    } exp_t;

    exp_t q[$];

    rx_token_check_if #(.CNT_W(8)) bus ();

    rx_token_check #(.CNT_W(8)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h (cycle %0d)", nm, act, exp, cyc);
        end
    endtask

    task automatic step(input logic sop, input logic bv, input logic [7:0] b, input logic eop);
        bus.rx_sop        = sop;
        bus.rx_byte_valid = bv;
        bus.rx_byte       = b;
        bus.rx_eop        = eop;
        @(posedge clk);
        #1;
        bus.rx_sop        = 1'b0;
        bus.rx_byte_valid = 1'b0;
        bus.rx_byte       = 8'h00;
        bus.rx_eop        = 1'b0;
    endtask

    task automatic tok(input logic [7:0] p, input logic [7:0] b1, input logic [7:0] b2);
        step(1'b1, 1'b0, 8'h00, 1'b0);
        step(1'b0, 1'b1, p, 1'b0);
        step(1'b0, 1'b1, b1, 1'b0);
        step(1'b0, 1'b1, b2, 1'b0);
        step(1'b0, 1'b0, 8'h00, 1'b1);
    endtask

    task automatic exp_pid(input logic [3:0] p, input logic [6:0] a, input logic [3:0] e);
        exp_t x;
        x.is_err = 1'b0; x.pid = p; x.addr = a; x.endp = e; x.code = 2'b00; x.cyc = cyc;
        q.push_back(x);
    endtask

    task automatic exp_err(input logic [1:0] code);
        exp_t x;
        x.is_err = 1'b1; x.pid = 4'h0; x.addr = 7'h00; x.endp = 4'h0; x.code = code; x.cyc = cyc;
        q.push_back(x);
    endtask

    task automatic chk_all_zero(input string tag);
        chk({tag, ".pid_en"},   32'(bus.rx_pid_en),   32'h0);
        chk({tag, ".err_en"},   32'(bus.rx_err_en),   32'h0);
        chk({tag, ".pid"},      32'(bus.rx_pid),      32'h0);
        chk({tag, ".addr"},     32'(bus.rx_addr),     32'h0);
        chk({tag, ".endp"},     32'(bus.rx_endp),     32'h0);
        chk({tag, ".err_code"}, 32'(bus.rx_err_code), 32'h0);
        chk({tag, ".crc_cnt"},  32'(bus.crc_err_cnt), 32'h0);
        chk({tag, ".pid_cnt"},  32'(bus.pid_err_cnt), 32'h0);
    endtask

    // Monitor: every output pulse must match the oldest queued expectation.
    always @(negedge clk) begin
        if (!rst && (bus.rx_pid_en || bus.rx_err_en)) begin
            if (bus.rx_pid_en && bus.rx_err_en) begin
                n_chk++;
                n_fail++;
                $display("FAIL both_pulses: pid_en=1 err_en=1, expected at most one (cycle %0d)", cyc);
            end
            if (q.size() == 0) begin
                n_chk++;
                n_fail++;
                $display("FAIL unexpected_pulse: pid_en=%0b err_en=%0b, expected none (cycle %0d)",
                         bus.rx_pid_en, bus.rx_err_en, cyc);
            end else begin
                exp_t e;
                e = q.pop_front();
                chk("pulse_cycle", 32'(cyc), 32'(e.cyc));
                chk("pulse_kind",  32'(bus.rx_err_en), 32'(e.is_err));
                if (e.is_err) begin
                    chk("err_code", 32'(bus.rx_err_code), 32'(e.code));
                end else begin
                    chk("pid",  32'(bus.rx_pid),  32'(e.pid));
                    chk("addr", 32'(bus.rx_addr), 32'(e.addr));
                    chk("endp", 32'(bus.rx_endp), 32'(e.endp));
                end
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached, expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        rst                 = 1'b1;
        bus.rx_sop          = 1'b0;
        bus.rx_byte_valid   = 1'b0;
        bus.rx_byte         = 8'h00;
        bus.rx_eop          = 1'b0;
        bus.rx_handshake_on = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        chk_all_zero("reset");
        rst = 1'b0;
        step(1'b0, 1'b0, 8'h00, 1'b0);

        // SETUP, IN, OUT to address 0 / endpoint 0, back-to-back
        tok(8'h2D, 8'h00, 8'h10); exp_pid(4'hD, 7'h00, 4'h0);
        tok(8'h69, 8'h00, 8'h10); exp_pid(4'h9, 7'h00, 4'h0);
        tok(8'hE1, 8'h00, 8'h10); exp_pid(4'h1, 7'h00, 4'h0);

        // IN to address 1, last byte and eop in the same cycle
        step(1'b1, 1'b0, 8'h00, 1'b0);
        step(1'b0, 1'b1, 8'h69, 1'b0);
        step(1'b0, 1'b1, 8'h01, 1'b0);
        step(1'b0, 1'b1, 8'hE8, 1'b1); exp_pid(4'h9, 7'h01, 4'h0);

        // SETUP to address 0 / endpoint 1
        tok(8'h2D, 8'h80, 8'hA0); exp_pid(4'hD, 7'h00, 4'h1);

        // Bad CRC: error 10, outputs held
        tok(8'h69, 8'h00, 8'h11); exp_err(2'b10);
        step(1'b0, 1'b0, 8'h00, 1'b0);
        chk("crc_cnt_1",  32'(bus.crc_err_cnt), 32'd1);
        chk("pid_held",   32'(bus.rx_pid),      32'hD);
        chk("endp_held",  32'(bus.rx_endp),     32'h1);

        // ACK accepted, then dropped while handshakes are disabled
        step(1'b1, 1'b0, 8'h00, 1'b0);
        step(1'b0, 1'b1, 8'hD2, 1'b0);
        step(1'b0, 1'b0, 8'h00, 1'b1); exp_pid(4'h2, 7'h00, 4'h1);
        bus.rx_handshake_on = 1'b0;
        step(1'b1, 1'b0, 8'h00, 1'b0);
        step(1'b0, 1'b1, 8'hD2, 1'b1);
        step(1'b0, 1'b0, 8'h00, 1'b0);
        bus.rx_handshake_on = 1'b1;
        chk("ack_drop_pid", 32'(bus.rx_pid), 32'h2);

        // Corrupted PID: error 01 right after the PID byte, rest ignored
        step(1'b1, 1'b0, 8'h00, 1'b0);
        step(1'b0, 1'b1, 8'h6A, 1'b0); exp_err(2'b01);
        step(1'b0, 1'b1, 8'h00, 1'b0);
        step(1'b0, 1'b1, 8'h10, 1'b0);
        step(1'b0, 1'b0, 8'h00, 1'b1);
        chk("pid_cnt_1", 32'(bus.pid_err_cnt), 32'd1);

        // DATA0 is silently skipped
        tok(8'hC3, 8'h00, 8'h00);
        step(1'b0, 1'b0, 8'h00, 1'b0);

        // Short packet, then recovery
        step(1'b1, 1'b0, 8'h00, 1'b0);
        step(1'b0, 1'b1, 8'h69, 1'b0);
        step(1'b0, 1'b1, 8'h00, 1'b0);
        step(1'b0, 1'b0, 8'h00, 1'b1); exp_err(2'b11);
        tok(8'hE1, 8'h00, 8'h10); exp_pid(4'h1, 7'h00, 4'h0);

        // Long packet, then recovery
        step(1'b1, 1'b0, 8'h00, 1'b0);
        step(1'b0, 1'b1, 8'h69, 1'b0);
        step(1'b0, 1'b1, 8'h00, 1'b0);
        step(1'b0, 1'b1, 8'h10, 1'b0);
        step(1'b0, 1'b1, 8'hFF, 1'b0); exp_err(2'b11);
        step(1'b0, 1'b0, 8'h00, 1'b1);
        tok(8'hE1, 8'h00, 8'h10); exp_pid(4'h1, 7'h00, 4'h0);

        // Abort in TOK1; the aborting sop starts the next packet
        step(1'b1, 1'b0, 8'h00, 1'b0);
        step(1'b0, 1'b1, 8'h69, 1'b0);
        step(1'b1, 1'b1, 8'h55, 1'b0); exp_err(2'b11);
        step(1'b0, 1'b1, 8'hE1, 1'b0);
        step(1'b0, 1'b1, 8'h00, 1'b0);
        step(1'b0, 1'b1, 8'h10, 1'b0);
        step(1'b0, 1'b0, 8'h00, 1'b1); exp_pid(4'h1, 7'h00, 4'h0);

        // CRC error counter saturation: 300 bad packets in total
        for (int i = 1; i < 300; i++) begin
            tok(8'h69, 8'h00, 8'h11); exp_err(2'b10);
        end
        step(1'b0, 1'b0, 8'h00, 1'b0);
        chk("crc_cnt_sat", 32'(bus.crc_err_cnt), 32'd255);

        // Reset while in TOK2
        step(1'b1, 1'b0, 8'h00, 1'b0);
        step(1'b0, 1'b1, 8'hE1, 1'b0);
        step(1'b0, 1'b1, 8'h00, 1'b0);
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        chk_all_zero("mid_reset");
        step(1'b0, 1'b1, 8'h10, 1'b0);
        step(1'b0, 1'b0, 8'h00, 1'b1);
        step(1'b0, 1'b0, 8'h00, 1'b0);
        tok(8'h69, 8'h01, 8'hE8); exp_pid(4'h9, 7'h01, 4'h0);

        repeat (4) step(1'b0, 1'b0, 8'h00, 1'b0);
        chk("pending_expectations", 32'(q.size()), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
